// File: rtl/general_pack.sv
// Shared constants and state encoding for the key/sync driver.
// Imported by the deserializer and the top level.
package general_pack;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int CFG_BYTES       = 2 * AES_BLOCK_BYTES;
  localparam int CFG_IDX_W       = $clog2(CFG_BYTES);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } dvr_state_t;

endpackage

// File: rtl/cfg_byte_deserializer.sv
// Collects 32 config bytes MSB-first into a 256-bit {key, sync} word.
// Ports: i_clk, i_rst, i_en (accept strobe), i_data -> o_last, o_word.
module cfg_byte_deserializer
  import general_pack::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [7:0]               i_data,
  output logic                     o_last,
  output logic [CFG_BYTES*8-1:0]   o_word
);

  logic [CFG_IDX_W-1:0]   r_idx;
  logic [CFG_BYTES*8-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      // 5-bit index wraps 31 -> 0 on its own
      r_idx   <= r_idx + 1'b1;
      r_shift <= {r_shift[CFG_BYTES*8-9:0], i_data};
    end
  end

  assign o_last = i_en &&
                  (r_idx == CFG_IDX_W'(CFG_BYTES - 1));

  // Word as it stands including the byte being accepted now,
  // so the top can capture it on the same edge as byte 31.
  assign o_word = {r_shift[CFG_BYTES*8-9:0], i_data};

endmodule

// File: rtl/sync_key_dvr_master.sv
// Master end of the AES key/sync port: loads key+sync from a byte
// stream, then issues block_count transfers with sync incrementing.
// Ports: i_clk, i_rst, cfg byte stream (i_cfg_data/i_cfg_valid/
// o_cfg_rdy), i_block_count, o_done, o_key, o_sync, o_valid, i_rdy.
module sync_key_dvr_master
  import general_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [7:0]                     i_cfg_data,
  input  logic                           i_cfg_valid,
  output logic                           o_cfg_rdy,
  input  logic [COUNT_WIDTH-1:0]         i_block_count,
  output logic                           o_done,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] o_key,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] o_sync,
  output logic                           o_valid,
  input  logic                           i_rdy
);

  localparam int KW = DATA_WIDTH_IN_BYTES * 8;

  dvr_state_t             r_state;
  dvr_state_t             w_next;
  logic [COUNT_WIDTH-1:0] r_remain;
  logic [KW-1:0]          r_key;
  logic [KW-1:0]          r_sync;
  logic                   r_valid;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_last;
  logic [2*KW-1:0]        w_word;
  logic                   w_hs;
  logic                   w_final_hs;

  // cfg_rdy is the only combinational output
  assign o_cfg_rdy = (r_state == ST_LOAD) && !i_rst;
  assign w_accept  = i_cfg_valid && o_cfg_rdy;

  cfg_byte_deserializer u_deser (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_accept),
    .i_data (i_cfg_data),
    .o_last (w_last),
    .o_word (w_word)
  );

  assign w_hs       = r_valid && i_rdy;
  assign w_final_hs = w_hs &&
                      (r_remain == COUNT_WIDTH'(1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_LOAD: begin
        if (w_last) begin
          if (i_block_count != '0) w_next = ST_ISSUE;
          else                     w_next = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (w_final_hs) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_LOAD;
      end
      default: begin
        w_next = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LOAD;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // valid/done registered from next state
      r_valid <= (w_next == ST_ISSUE);
      r_done  <= (w_next == ST_DONE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_remain <= '0;
    end else if (w_last) begin
      r_remain <= i_block_count;
    end else if (w_hs) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key  <= '0;
      r_sync <= '0;
    end else if (w_last) begin
      r_key  <= w_word[2*KW-1:KW];
      r_sync <= w_word[KW-1:0];
    end else if (w_hs) begin
      // CTR-style counter, wraps modulo 2^128
      r_sync <= r_sync + 1'b1;
    end
  end

  assign o_key   = r_key;
  assign o_sync  = r_sync;
  assign o_valid = r_valid;
  assign o_done  = r_done;

endmodule

// File: tb/tb_sync_key_dvr_master.sv
// Directed bench for sync_key_dvr_master.
// Drives and samples on the falling edge.
module tb_sync_key_dvr_master;

  logic         clk;
  logic         rst;
  logic [7:0]   cfg_data;
  logic         cfg_valid;
  logic         cfg_rdy;
  logic [15:0]  block_count;
  logic         done;
  logic [127:0] key;
  logic [127:0] sync;
  logic         valid;
  logic         rdy;

  int pass_cnt;
  int total;
  int hs_cnt;

  localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] S0 = 128'h101112131415161718191A1B1C1D1E1F;

  sync_key_dvr_master #(
    .DATA_WIDTH_IN_BYTES (16),
    .COUNT_WIDTH         (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cfg_data    (cfg_data),
    .i_cfg_valid   (cfg_valid),
    .o_cfg_rdy     (cfg_rdy),
    .i_block_count (block_count),
    .o_done        (done),
    .o_key         (key),
    .o_sync        (sync),
    .o_valid       (valid),
    .i_rdy         (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid && rdy) hs_cnt = hs_cnt + 1;
  end

  // Offer nbytes bytes; returns just after the edge that accepts
  // the last one, with cfg_valid dropped.
  task automatic load(input logic [127:0] k,
                      input logic [127:0] s,
                      input logic [15:0]  cnt,
                      input int           nbytes,
                      input bit           gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    block_count = cnt;
    while (i < nbytes && guard < 1000) begin
      @(negedge clk);
      guard++;
      cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i < 16) cfg_data = k[127 - 8*i -: 8];
      else        cfg_data = s[127 - 8*(i-16) -: 8];
      if (cfg_valid && cfg_rdy) i++;
    end
    total++;
    if (guard >= 1000)
      $display("FAIL load_timeout accepted=%0d want=%0d", i, nbytes);
    else
      pass_cnt++;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Expects cnt back-to-back transfers (rdy high), then done.
  task automatic check_issue(input logic [127:0] k,
                             input logic [127:0] s,
                             input int           cnt,
                             input bit           junk);
    logic [127:0] exp;
    int base;
    base = hs_cnt;
    for (int j = 0; j < cnt; j++) begin
      @(negedge clk);
      exp = s + 128'(j);
      total++;
      if (valid !== 1'b1 || key !== k || sync !== exp ||
          cfg_rdy !== 1'b0) begin
        $display("FAIL issue_%0d v=%b key=%h sync=%h rdy=%b want sync=%h key=%h",
                 j, valid, key, sync, cfg_rdy, exp, k);
      end else pass_cnt++;
      cfg_valid = junk;
      cfg_data  = 8'hEE;
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || done !== 1'b1 || cfg_rdy !== 1'b0)
      $display("FAIL done_cycle v=%b done=%b rdy=%b want 0 1 0",
               valid, done, cfg_rdy);
    else pass_cnt++;
    cfg_valid = 1'b0;
    @(negedge clk);
    exp = s + 128'(cnt);
    total++;
    if (done !== 1'b0 || cfg_rdy !== 1'b1 || sync !== exp ||
        key !== k || hs_cnt - base !== cnt)
      $display("FAIL after_done done=%b rdy=%b sync=%h hs=%0d want 0 1 %h %0d",
               done, cfg_rdy, sync, hs_cnt - base, exp, cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (valid !== 1'b0 || done !== 1'b0 || key !== '0 ||
        sync !== '0 || cfg_rdy !== 1'b0)
      $display("FAIL reset v=%b d=%b key=%h sync=%h rdy=%b want all 0",
               valid, done, key, sync, cfg_rdy);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg_rdy !== 1'b1)
      $display("FAIL reset_release cfg_rdy=%b want 1", cfg_rdy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    rdy = 1'b1;
    load(K0, S0, 16'd3, 32, 1'b0);
    check_issue(K0, S0, 3, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [127:0] k;
    logic [127:0] s;
    int base;
    k = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    s = 128'h0000_0000_0000_0000_0000_0000_0000_00FE;
    rdy = 1'b0;
    base = hs_cnt;
    load(k, s, 16'd2, 32, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || sync !== s || key !== k)
        $display("FAIL stall_%0d v=%b sync=%h want 1 %h", j, valid, sync, s);
      else pass_cnt++;
    end
    rdy = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || sync !== s + 128'd1)
      $display("FAIL bp_second v=%b sync=%h want 1 %h", valid, sync, s + 128'd1);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || done !== 1'b1 || sync !== s + 128'd2 ||
        hs_cnt - base !== 2)
      $display("FAIL bp_done v=%b d=%b sync=%h hs=%0d want 0 1 %h 2",
               valid, done, sync, hs_cnt - base, s + 128'd2);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [127:0] k;
    k = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    rdy = 1'b1;
    load(k, {128{1'b1}}, 16'd2, 32, 1'b0);
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || sync !== {128{1'b1}})
      $display("FAIL wrap_first v=%b sync=%h want all ones", valid, sync);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid !== 1'b1 || sync !== 128'd0 || key !== k)
      $display("FAIL wrap_second v=%b sync=%h key=%h want 1 0 %h",
               valid, sync, key, k);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || valid !== 1'b0 || sync !== 128'd1)
      $display("FAIL wrap_done d=%b v=%b sync=%h want 1 0 1", done, valid, sync);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_zero_count();
    int base;
    base = hs_cnt;
    rdy = 1'b1;
    load(K0, S0, 16'd0, 32, 1'b0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || valid !== 1'b0 || cfg_rdy !== 1'b0)
      $display("FAIL zero_done d=%b v=%b rdy=%b want 1 0 0",
               done, valid, cfg_rdy);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || valid !== 1'b0 || cfg_rdy !== 1'b1 ||
        hs_cnt !== base || sync !== S0)
      $display("FAIL zero_after d=%b v=%b rdy=%b hs=%0d sync=%h want 0 0 1 0 %h",
               done, valid, cfg_rdy, hs_cnt - base, sync, S0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load(K0, S0, 16'd3, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || key !== '0 || sync !== '0 || cfg_rdy !== 1'b0)
      $display("FAIL rst_load v=%b key=%h sync=%h rdy=%b want 0 0 0 0",
               valid, key, sync, cfg_rdy);
    else pass_cnt++;
    rst = 1'b0;
    test_basic();
    rdy = 1'b1;
    load(K0, S0, 16'd7, 32, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || key !== '0 || sync !== '0 || cfg_rdy !== 1'b0 ||
        done !== 1'b0)
      $display("FAIL rst_issue v=%b key=%h sync=%h rdy=%b d=%b want 0",
               valid, key, sync, cfg_rdy, done);
    else pass_cnt++;
    rst = 1'b0;
    test_basic();
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1;
    logic [127:0] s1;
    logic [127:0] k2;
    logic [127:0] s2;
    k1 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    s1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    k2 = 128'hFEDCBA98_76543210_F0E1D2C3_B4A59687;
    s2 = 128'h00000000_00000000_00000000_FFFFFFFF;
    rdy = 1'b1;
    load(k1, s1, 16'd2, 32, 1'b1);
    check_issue(k1, s1, 2, 1'b1);
    load(k2, s2, 16'd2, 32, 1'b1);
    check_issue(k2, s2, 2, 1'b0);
  endtask

  initial begin
    pass_cnt    = 0;
    total       = 0;
    hs_cnt      = 0;
    rst         = 1'b1;
    cfg_data    = 8'h00;
    cfg_valid   = 1'b0;
    block_count = 16'd0;
    rdy         = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
